// File: rtl/irq_arbiter8_if.sv
// irq_arbiter8_if: peripheral/core-facing signal bundle of the eight-source interrupt arbiter
interface irq_arbiter8_if;
  logic [7:0] src;
  logic       en_we;
  logic [7:0] en_wdata;
  logic [7:0] en_mask;
  logic [7:0] pending;
  logic       irq;
  logic [2:0] irq_id;
  logic       ack;
  logic       complete;
  logic       busy;
  modport master (output src, en_we, en_wdata, ack, complete,
                  input en_mask, pending, irq, irq_id, busy);
  modport slave  (input src, en_we, en_wdata, ack, complete,
                  output en_mask, pending, irq, irq_id, busy);
endinterface

// File: rtl/irq_arbiter8.sv
// irq_arbiter8: latches/masks eight interrupt sources and runs a request/claim/complete handshake
module irq_arbiter8 #(
  parameter logic [7:0] EDGE_MASK = 8'hFF
) (
  input logic clk,
  input logic rst,
  irq_arbiter8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t     state;
  logic [7:0] src_q, pend_q, cand, set, clr;
  logic [2:0] winner;
  logic       hit;
  assign bus.pending = (pend_q & EDGE_MASK) | (bus.src & ~EDGE_MASK);
  assign cand = bus.pending & bus.en_mask;
  assign hit = |cand;
  assign set = bus.src & ~src_q & EDGE_MASK;
  assign clr = (state == REQ && bus.ack) ? 8'b1 << bus.irq_id : 8'b0;
  always_comb begin
    winner = 3'd0;
    for (int i = 0; i < 8; i++)
      winner = cand[i] ? i[2:0] : winner;
  end
  // set is ORed after the clear so a re-edge during the claim re-pends the source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      src_q       <= '0;
      pend_q      <= '0;
      bus.en_mask <= '0;
      bus.irq     <= 1'b0;
      bus.irq_id  <= '0;
      bus.busy    <= 1'b0;
    end else begin
      src_q  <= bus.src;
      pend_q <= ((pend_q & ~clr) | set) & EDGE_MASK;
      if (bus.en_we) bus.en_mask <= bus.en_wdata;
      case (state)
        IDLE: if (hit) begin
          state      <= REQ;
          bus.irq    <= 1'b1;
          bus.irq_id <= winner;
        end
        REQ: if (bus.ack) begin
          state    <= SERVICE;
          bus.irq  <= 1'b0;
          bus.busy <= 1'b1;
        end else if (!hit) begin
          state   <= IDLE;
          bus.irq <= 1'b0;
        end else bus.irq_id <= winner;
        SERVICE: if (bus.complete) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
